tx_frame_packer: RTL and testbench

TX_FRAME_PACKER -- requirements
Module: tx_frame_packer

---
 rtl/tx_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_tx_frame_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_packer.sv
// Ethernet-style TX frame packer: emits a 14-byte MAC header, a fixed-length
// payload taken from an upstream byte stream, zero padding up to the 46-byte
// minimum payload, then holds off for an inter-frame gap.
module tx_frame_packer #(
    parameter logic [47:0] DEST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int unsigned MinPayload = 46;
    localparam bit          NeedPad    = (PAYLOAD_LEN < MinPayload);
    localparam logic [10:0] LenEnd     = 11'(PAYLOAD_LEN);
    localparam logic [10:0] LenLast    = 11'(PAYLOAD_LEN - 1);
    localparam logic [10:0] PadEnd     = 11'(MinPayload);
    localparam logic [10:0] PadLast    = 11'(MinPayload - 1);
    localparam logic [10:0] HdrLast    = 11'd13;
    localparam logic [7:0]  GapLast    = 8'(IFG_CYCLES - 1);
    // Header bytes in transmit order, first byte in the top octet.
    localparam logic [111:0] Header    = {DEST_MAC, SRC_MAC, 16'(PAYLOAD_LEN)};

    typedef enum logic [2:0] {StIdle, StHeader, StPayload, StPad, StGap} state_e;

    state_e        state_q, state_d;
    logic          tvalid_q, tvalid_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic [10:0]   cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          load;
    logic          last_accept;
    logic [111:0]  hdr_shift;
    logic [7:0]    hdr_byte;

    assign load        = !tvalid_q || m_axis_tready;
    assign last_accept = tvalid_q && m_axis_tready && tlast_q;
    assign hdr_shift   = Header << {cnt_q, 3'b000};
    assign hdr_byte    = hdr_shift[111:104];

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != StIdle);
    assign frame_count   = frame_count_q;

    // Next-state, output-register load and input handshake.
    always_comb begin
        state_d       = state_q;
        tvalid_d      = tvalid_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        frame_count_d = frame_count_q;
        in_ready      = 1'b0;

        // Pending beat leaves on a free slot unless something new is loaded.
        if (load) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (enable && load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = Header[111:104];
                    cnt_d    = 11'd1;
                    state_d  = StHeader;
                end
            end
            StHeader: begin
                if (load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hdr_byte;
                    if (cnt_q == HdrLast) begin
                        cnt_d   = '0;
                        state_d = StPayload;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            StPayload: begin
                // Once all payload bytes are in, wait here for the tlast beat.
                if (cnt_q != LenEnd) begin
                    in_ready = load;
                    if (load && in_valid) begin
                        tvalid_d = 1'b1;
                        tdata_d  = in_data;
                        cnt_d    = cnt_q + 11'd1;
                        if (cnt_q == LenLast) begin
                            if (NeedPad) begin
                                state_d = StPad;
                            end else begin
                                tlast_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StPad: begin
                if (load && (cnt_q != PadEnd)) begin
                    tvalid_d = 1'b1;
                    tdata_d  = 8'h00;
                    tlast_d  = (cnt_q == PadLast);
                    cnt_d    = cnt_q + 11'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (last_accept) begin
            state_d       = StGap;
            cnt_d         = '0;
            gap_d         = '0;
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tvalid_q      <= 1'b0;
            tdata_q       <= 8'h00;
            tlast_q       <= 1'b0;
            cnt_q         <= '0;
            gap_q         <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Directed bench for tx_frame_packer: nominal, backpressure, input bubbles,
// mid-frame reset, enable drop (64-byte instance) and padding (10-byte instance).
module tb_tx_frame_packer;

    localparam logic [47:0] DestA   = 48'h11_22_33_44_55_66;
    localparam logic [47:0] DestDef = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SrcDef  = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable   [2];
    logic        in_valid [2];
    logic [7:0]  in_data  [2];
    logic        in_ready [2];
    logic        tvalid   [2];
    logic [7:0]  tdata    [2];
    logic        tlast    [2];
    logic        tready   [2];
    logic        busy     [2];
    logic [15:0] fcount   [2];

    int          tests;
    int          fails;
    logic [7:0]  got_d [256];
    logic        got_l [256];
    logic [7:0]  exp_d [256];
    int          exp_n;
    int          nbeats;
    int          nin;
    int          low_cyc;
    bit          saw_last;
    int          gap_cyc;
    int          low_tot;
    bit          seen;

    always #5 clk = ~clk;

    tx_frame_packer #(
        .DEST_MAC   (DestA),
        .SRC_MAC    (SrcDef),
        .PAYLOAD_LEN(64),
        .IFG_CYCLES (12)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable[0]),
        .in_valid     (in_valid[0]),
        .in_data      (in_data[0]),
        .in_ready     (in_ready[0]),
        .m_axis_tvalid(tvalid[0]),
        .m_axis_tdata (tdata[0]),
        .m_axis_tlast (tlast[0]),
        .m_axis_tready(tready[0]),
        .busy         (busy[0]),
        .frame_count  (fcount[0])
    );

    tx_frame_packer #(
        .DEST_MAC   (DestDef),
        .SRC_MAC    (SrcDef),
        .PAYLOAD_LEN(10),
        .IFG_CYCLES (12)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable[1]),
        .in_valid     (in_valid[1]),
        .in_data      (in_data[1]),
        .in_ready     (in_ready[1]),
        .m_axis_tvalid(tvalid[1]),
        .m_axis_tdata (tdata[1]),
        .m_axis_tlast (tlast[1]),
        .m_axis_tready(tready[1]),
        .busy         (busy[1]),
        .frame_count  (fcount[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Expected beat sequence: header, payload 0,1,2,..., zero pad to 46.
    task automatic build_exp(input logic [47:0] dest, input int len);
        logic [15:0] l16;
        l16 = 16'(len);
        for (int i = 0; i < 6; i++) begin
            exp_d[i]     = dest[(47 - 8 * i) -: 8];
            exp_d[6 + i] = SrcDef[(47 - 8 * i) -: 8];
        end
        exp_d[12] = l16[15:8];
        exp_d[13] = l16[7:0];
        exp_n = 14 + ((len < 46) ? 46 : len);
        for (int i = 14; i < exp_n; i++) begin
            exp_d[i] = (i - 14 < len) ? 8'(i - 14) : 8'h00;
        end
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_beats"}, nbeats, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], (i == exp_n - 1) ? 1 : 0);
        end
    endtask

    // Runs one frame (or part of one) on instance d. Entered and left just
    // after a rising edge; outputs are sampled on the falling edge.
    task automatic cap(input int d, input int tr_mode, input int bub_after, input int stop_in,
                       input int drop_en, input int max_cyc);
        int         bub_left;
        bit         stalled;
        bit         acc_in;
        bit         done;
        logic [7:0] hold_d;
        logic       hold_l;
        nbeats = 0; nin = 0; low_cyc = 0; saw_last = 0;
        bub_left = 0; stalled = 0; done = 0; hold_d = 8'h00; hold_l = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = 8'h00;
        tready[d]   = 1'b1;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk);
            if (stalled) begin
                chk("stall_tvalid", tvalid[d], 1);
                chk("stall_tdata", tdata[d], hold_d);
                chk("stall_tlast", tlast[d], hold_l);
            end
            acc_in = in_valid[d] && in_ready[d];
            if (nbeats > 0 && !tvalid[d]) low_cyc++;
            if (tvalid[d] && tready[d]) begin
                got_d[nbeats] = tdata[d];
                got_l[nbeats] = tlast[d];
                nbeats++;
                if (tlast[d]) begin
                    saw_last = 1;
                    done     = 1;
                end
            end
            stalled = tvalid[d] && !tready[d];
            hold_d  = tdata[d];
            hold_l  = tlast[d];
            @(posedge clk);
            #1;
            if (acc_in) begin
                nin++;
                in_data[d] = 8'(nin);
            end
            if (acc_in && nin == bub_after) bub_left = 5;
            if (bub_left > 0) begin
                in_valid[d] = 1'b0;
                bub_left--;
            end else begin
                in_valid[d] = 1'b1;
            end
            if (tr_mode == 1) tready[d] = ~tready[d];
            if (drop_en != 0 && nbeats == 2) enable[d] = 1'b0;
            if (stop_in > 0 && nin == stop_in) done = 1;
        end
        chk("cap_done", 32'(done), 1);
    endtask

    // Counts cycles until the next frame's first beat appears.
    task automatic wait_start(input int d, input int max_cyc, output int gap, output int low);
        bit found;
        found = 0; gap = 0; low = 0;
        for (int c = 0; c < max_cyc && !found; c++) begin
            if (tvalid[d]) begin
                found = 1;
            end else begin
                low++;
                if (busy[d]) gap++;
                @(posedge clk);
                #1;
            end
        end
        chk("frame_start", 32'(found), 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            enable[d]   = 1'b0;
            in_valid[d] = 1'b0;
            in_data[d]  = 8'h00;
            tready[d]   = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid[0], 0);
        chk("rst_tdata", tdata[0], 0);
        chk("rst_tlast", tlast[0], 0);
        chk("rst_in_ready", in_ready[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_fcount", fcount[0], 0);
        chk("rst_b_busy", busy[1], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_start", tvalid[0], 0);
        chk("idle_busy", busy[0], 0);

        // Nominal frame, continuous input, tready high.
        enable[0] = 1'b1;
        build_exp(DestA, 64);
        cap(0, 0, 0, 0, 0, 400);
        cmp_frame("nom");
        chk("nom_nin", nin, 64);
        chk("nom_bubbles", low_cyc, 0);
        chk("nom_fcount", fcount[0], 1);
        wait_start(0, 100, gap_cyc, low_tot);
        chk("nom_gap_cycles", gap_cyc, 12);
        chk("nom_low_total", low_tot, 13);

        // Backpressure: tready alternates; sequence identical to nominal.
        cap(0, 1, 0, 0, 0, 800);
        cmp_frame("bp");
        chk("bp_nin", nin, 64);
        chk("bp_fcount", fcount[0], 2);
        wait_start(0, 100, gap_cyc, low_tot);

        // Input bubble of 5 cycles after the 20th payload byte.
        cap(0, 0, 20, 0, 0, 400);
        cmp_frame("bub");
        chk("bub_nin", nin, 64);
        chk("bub_low", low_cyc, 5);
        chk("bub_fcount", fcount[0], 3);
        wait_start(0, 100, gap_cyc, low_tot);

        // Reset for one cycle after 20 payload bytes.
        cap(0, 0, 0, 20, 0, 400);
        chk("rstmid_no_tlast", 32'(saw_last), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_tvalid", tvalid[0], 0);
        chk("rstmid_tdata", tdata[0], 0);
        chk("rstmid_tlast", tlast[0], 0);
        chk("rstmid_in_ready", in_ready[0], 0);
        chk("rstmid_busy", busy[0], 0);
        chk("rstmid_fcount", fcount[0], 0);
        rst_n = 1'b1;
        cap(0, 0, 0, 0, 0, 400);
        chk("rstmid_first_byte", got_d[0], 8'h11);
        cmp_frame("rstmid");
        chk("rstmid_fcount_after", fcount[0], 1);

        // Enable dropped during the header: frame still completes.
        wait_start(0, 100, gap_cyc, low_tot);
        cap(0, 0, 0, 0, 1, 400);
        cmp_frame("endrop");
        chk("endrop_fcount", fcount[0], 2);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (tvalid[0]) seen = 1;
        end
        chk("endrop_no_restart", 32'(seen), 0);
        chk("endrop_idle", busy[0], 0);
        chk("endrop_fcount_hold", fcount[0], 2);

        // Padding on the 10-byte instance.
        enable[1] = 1'b1;
        build_exp(DestDef, 10);
        cap(1, 0, 0, 0, 0, 400);
        cmp_frame("pad");
        chk("pad_nin", nin, 10);
        chk("pad_fcount", fcount[1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
